// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants: RV32 opcode encodings, hazard FSM state
// encodings and the source-register usage decode used by hazard detection.
package pipe_ctrl_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_BR_FLUSH = 2'd2
   } ctrl_state_t;

   function automatic logic uses_rs1(input logic [6:0] opc);
      return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opc);
      return (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Flags when the decode instruction actually reads the register a load in EX writes.
// Purely combinational; x0 is never a dependency.
module hazard_cmp
   import pipe_ctrl_pkg::*;
(
   input  logic [6:0] id_opcode,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic [4:0] ex_rd,
   output logic       match
);

   always_comb begin
      match = 1'b0;
      if (ex_rd != 5'd0) begin
         match = (uses_rs1(id_opcode) && (id_rs1 == ex_rd)) ||
                 (uses_rs2(id_opcode) && (id_rs2 == ex_rd));
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush outputs are combinational from state and inputs (zero latency);
// mem_busy freezes IF/ID/EX. HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_,
   input  logic       id_valid,
   input  logic [6:0] id_opcode,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       ex_valid,
   input  logic [6:0] ex_opcode,
   input  logic [4:0] ex_rd,
   input  logic       br_taken,
   input  logic       mem_busy,
   output logic       stall_if,
   output logic       stall_id,
   output logic       stall_ex,
   output logic       flush_if,
   output logic       flush_id,
   output logic [1:0] ctrl_state
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   ctrl_state_t state;
   ctrl_state_t state_nxt;
   logic        src_match;
   logic        load_use;

   hazard_cmp u_cmp (
      .id_opcode (id_opcode),
      .id_rs1    (id_rs1),
      .id_rs2    (id_rs2),
      .ex_rd     (ex_rd),
      .match     (src_match)
   );

   assign load_use   = ex_valid && (ex_opcode == OPC_LOAD) && id_valid && src_match;
   assign ctrl_state = state;

   // MEM_WAIT needs no branch of its own: once mem_busy drops it resolves exactly like RUN.
   always_comb begin
      state_nxt = ST_RUN;
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      stall_ex  = 1'b0;
      flush_if  = 1'b0;
      flush_id  = 1'b0;
      if (!rst_) begin
         if (mem_busy) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            state_nxt = ST_MEM_WAIT;
         end else if (br_taken) begin
            flush_if  = 1'b1;
            flush_id  = 1'b1;
            state_nxt = ST_BR_FLUSH;
         end else if (state == ST_BR_FLUSH) begin
            // IF_ID was squashed last cycle, so decode holds nothing to check for load-use.
            flush_if  = 1'b1;
         end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            flush_id  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_if && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
         if (flush_if && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expected vectors are hand-derived as
// {stall_if, stall_id, stall_ex, flush_if, flush_id, ctrl_state[1:0]}.
module tb_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   localparam logic [6:0] OPC_ADDI = 7'b0010011;

   logic       clk = 1'b0;
   logic       rst_;
   logic       id_valid;
   logic [6:0] id_opcode;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       ex_valid;
   logic [6:0] ex_opcode;
   logic [4:0] ex_rd;
   logic       br_taken;
   logic       mem_busy;
   logic       stall_if;
   logic       stall_id;
   logic       stall_ex;
   logic       flush_if;
   logic       flush_id;
   logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   logic [6:0] obs;
   int checks = 0;
   int errors = 0;

   assign obs = {stall_if, stall_id, stall_ex, flush_if, flush_id, ctrl_state};

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk        (clk),
      .rst_       (rst_),
      .id_valid   (id_valid),
      .id_opcode  (id_opcode),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .ex_valid   (ex_valid),
      .ex_opcode  (ex_opcode),
      .ex_rd      (ex_rd),
      .br_taken   (br_taken),
      .mem_busy   (mem_busy),
      .stall_if   (stall_if),
      .stall_id   (stall_id),
      .stall_ex   (stall_ex),
      .flush_if   (flush_if),
      .flush_id   (flush_id),
      .ctrl_state (ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
`endif
   );

   typedef struct packed {
      logic       idv;
      logic [6:0] idop;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       exv;
      logic [6:0] exop;
      logic [4:0] rd;
      logic       br;
      logic       mem;
      logic [6:0] exp;
   } vec_t;

   function automatic vec_t v(input logic idv, input logic [6:0] idop, input logic [4:0] r1,
                              input logic [4:0] r2, input logic exv, input logic [6:0] exop,
                              input logic [4:0] rd, input logic br, input logic mem,
                              input logic [6:0] e);
      vec_t t;
      t.idv = idv; t.idop = idop; t.rs1 = r1; t.rs2 = r2;
      t.exv = exv; t.exop = exop; t.rd = rd; t.br = br; t.mem = mem; t.exp = e;
      return t;
   endfunction

   // ex: lw x5 ; id: add x6,x5,x7
   function automatic vec_t lu(input logic br, input logic mem, input logic [6:0] e);
      return v(1'b1, OPC_OP, 5'd5, 5'd7, 1'b1, OPC_LOAD, 5'd5, br, mem, e);
   endfunction

   function automatic vec_t idle(input logic br, input logic mem, input logic [6:0] e);
      return v(1'b0, 7'd0, 5'd0, 5'd0, 1'b0, 7'd0, 5'd0, br, mem, e);
   endfunction

   task automatic drive(input vec_t t);
      id_valid  = t.idv;
      id_opcode = t.idop;
      id_rs1    = t.rs1;
      id_rs2    = t.rs2;
      ex_valid  = t.exv;
      ex_opcode = t.exop;
      ex_rd     = t.rd;
      br_taken  = t.br;
      mem_busy  = t.mem;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_ = 1'b1;
      drive(idle(1'b1, 1'b1, 7'd0));
      tick();
      @(negedge clk);
      checks++;
      if (obs !== 7'd0) begin
         errors++;
         $display("FAIL reset_hold: got %b expected %b", obs, 7'd0);
      end
      tick();
      rst_ = 1'b0;
      drive(idle(1'b0, 1'b0, 7'd0));
      @(negedge clk);
      checks++;
      if (obs !== 7'd0) begin
         errors++;
         $display("FAIL reset_release: got %b expected %b", obs, 7'd0);
      end
      tick();
   endtask

   task automatic test_load_use();
      vec_t tv[10];
      tv[0] = lu(1'b0, 1'b0, 7'b1100100);
      tv[1] = v(1'b1, OPC_OP,     5'd5, 5'd7, 1'b0, OPC_LOAD, 5'd5, 1'b0, 1'b0, 7'b0000000);
      tv[2] = v(1'b1, OPC_OP,     5'd7, 5'd5, 1'b1, OPC_LOAD, 5'd5, 1'b0, 1'b0, 7'b1100100);
      tv[3] = v(1'b1, OPC_STORE,  5'd1, 5'd5, 1'b1, OPC_LOAD, 5'd5, 1'b0, 1'b0, 7'b1100100);
      tv[4] = v(1'b1, OPC_BRANCH, 5'd9, 5'd5, 1'b1, OPC_LOAD, 5'd5, 1'b0, 1'b0, 7'b1100100);
      tv[5] = v(1'b1, OPC_ADDI,   5'd1, 5'd5, 1'b1, OPC_LOAD, 5'd5, 1'b0, 1'b0, 7'b0000000);
      tv[6] = v(1'b1, OPC_ADDI,   5'd5, 5'd0, 1'b1, OPC_LOAD, 5'd5, 1'b0, 1'b0, 7'b1100100);
      tv[7] = v(1'b0, OPC_OP,     5'd5, 5'd7, 1'b1, OPC_LOAD, 5'd5, 1'b0, 1'b0, 7'b0000000);
      tv[8] = v(1'b1, OPC_OP,     5'd5, 5'd7, 1'b1, OPC_OP,   5'd5, 1'b0, 1'b0, 7'b0000000);
      tv[9] = v(1'b1, OPC_LOAD,   5'd5, 5'd5, 1'b1, OPC_LOAD, 5'd5, 1'b0, 1'b0, 7'b1100100);
      for (int i = 0; i < 10; i++) begin
         drive(tv[i]);
         @(negedge clk);
         checks++;
         if (obs !== tv[i].exp) begin
            errors++;
            $display("FAIL load_use[%0d]: got %b expected %b", i, obs, tv[i].exp);
         end
         tick();
      end
   endtask

   task automatic test_x0_and_unused();
      vec_t tv[5];
      tv[0] = v(1'b1, OPC_OP,    5'd0, 5'd0, 1'b1, OPC_LOAD, 5'd0, 1'b0, 1'b0, 7'b0000000);
      tv[1] = v(1'b1, OPC_LUI,   5'd5, 5'd5, 1'b1, OPC_LOAD, 5'd5, 1'b0, 1'b0, 7'b0000000);
      tv[2] = v(1'b1, OPC_AUIPC, 5'd5, 5'd5, 1'b1, OPC_LOAD, 5'd5, 1'b0, 1'b0, 7'b0000000);
      tv[3] = v(1'b1, OPC_JAL,   5'd5, 5'd5, 1'b1, OPC_LOAD, 5'd5, 1'b0, 1'b0, 7'b0000000);
      tv[4] = v(1'b1, OPC_OP,    5'd5, 5'd0, 1'b1, OPC_LOAD, 5'd0, 1'b0, 1'b0, 7'b0000000);
      for (int i = 0; i < 5; i++) begin
         drive(tv[i]);
         @(negedge clk);
         checks++;
         if (obs !== tv[i].exp) begin
            errors++;
            $display("FAIL x0_unused[%0d]: got %b expected %b", i, obs, tv[i].exp);
         end
         tick();
      end
   endtask

   task automatic test_branch();
      vec_t tv[10];
      tv[0] = idle(1'b1, 1'b0, 7'b0001100);
      tv[1] = idle(1'b0, 1'b0, 7'b0001010);
      tv[2] = idle(1'b0, 1'b0, 7'b0000000);
      tv[3] = idle(1'b1, 1'b0, 7'b0001100);
      tv[4] = idle(1'b1, 1'b0, 7'b0001110);
      tv[5] = idle(1'b0, 1'b0, 7'b0001010);
      tv[6] = idle(1'b0, 1'b0, 7'b0000000);
      tv[7] = lu(1'b1, 1'b0, 7'b0001100);
      tv[8] = idle(1'b0, 1'b0, 7'b0001010);
      tv[9] = idle(1'b0, 1'b0, 7'b0000000);
      for (int i = 0; i < 10; i++) begin
         drive(tv[i]);
         @(negedge clk);
         checks++;
         if (obs !== tv[i].exp) begin
            errors++;
            $display("FAIL branch[%0d]: got %b expected %b", i, obs, tv[i].exp);
         end
         tick();
      end
   endtask

   task automatic test_mem_busy();
      vec_t tv[13];
      tv[0]  = lu(1'b1, 1'b1, 7'b1110000);
      tv[1]  = lu(1'b1, 1'b1, 7'b1110001);
      tv[2]  = lu(1'b1, 1'b1, 7'b1110001);
      tv[3]  = lu(1'b1, 1'b0, 7'b0001101);
      tv[4]  = idle(1'b0, 1'b0, 7'b0001010);
      tv[5]  = idle(1'b0, 1'b0, 7'b0000000);
      tv[6]  = idle(1'b0, 1'b1, 7'b1110000);
      tv[7]  = lu(1'b0, 1'b0, 7'b1100101);
      tv[8]  = idle(1'b0, 1'b0, 7'b0000000);
      tv[9]  = idle(1'b1, 1'b0, 7'b0001100);
      tv[10] = idle(1'b0, 1'b1, 7'b1110010);
      tv[11] = idle(1'b0, 1'b0, 7'b0000001);
      tv[12] = idle(1'b0, 1'b0, 7'b0000000);
      for (int i = 0; i < 13; i++) begin
         drive(tv[i]);
         @(negedge clk);
         checks++;
         if (obs !== tv[i].exp) begin
            errors++;
            $display("FAIL mem_busy[%0d]: got %b expected %b", i, obs, tv[i].exp);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_state();
      // Enter MEM_WAIT and keep mem_busy high, then assert reset between clock edges.
      drive(idle(1'b0, 1'b1, 7'd0));
      tick();
      @(negedge clk);
      checks++;
      if (obs !== 7'b1110001) begin
         errors++;
         $display("FAIL rst_pre_mem_wait: got %b expected %b", obs, 7'b1110001);
      end
      tick();
      #1;
      rst_ = 1'b1;
      #1;
      checks++;
      if (obs !== 7'd0) begin
         errors++;
         $display("FAIL rst_mid_mem_wait: got %b expected %b", obs, 7'd0);
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         errors++;
         $display("FAIL rst_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
      end
`endif
      tick();
      drive(idle(1'b0, 1'b0, 7'd0));
      rst_ = 1'b0;
      drive(lu(1'b0, 1'b0, 7'd0));
      @(negedge clk);
      checks++;
      if (obs !== 7'b1100100) begin
         errors++;
         $display("FAIL rst_resume: got %b expected %b", obs, 7'b1100100);
      end
      tick();
      drive(idle(1'b1, 1'b0, 7'd0));
      tick();
      drive(idle(1'b0, 1'b0, 7'd0));
      #2;
      rst_ = 1'b1;
      #1;
      checks++;
      if (obs !== 7'd0) begin
         errors++;
         $display("FAIL rst_mid_br_flush: got %b expected %b", obs, 7'd0);
      end
      rst_ = 1'b0;
      #1;
      checks++;
      if (obs !== 7'd0) begin
         errors++;
         $display("FAIL rst_release_br_flush: got %b expected %b", obs, 7'd0);
      end
      tick();
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic test_perf_cnt();
      rst_ = 1'b1;
      drive(idle(1'b0, 1'b0, 7'd0));
      tick();
      rst_ = 1'b0;
      drive(idle(1'b0, 1'b1, 7'd0));
      tick();
      drive(lu(1'b0, 1'b0, 7'd0));
      tick();
      drive(idle(1'b1, 1'b0, 7'd0));
      tick();
      drive(idle(1'b0, 1'b0, 7'd0));
      tick();
      @(negedge clk);
      checks++;
      if (stall_cnt !== 32'd2 || flush_cnt !== 32'd2) begin
         errors++;
         $display("FAIL perf_cnt: got %0d/%0d expected 2/2", stall_cnt, flush_cnt);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_load_use();
      test_x0_and_unused();
      test_branch();
      test_mem_busy();
      test_reset_mid_state();
`ifdef HAZARD_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
